// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, FIFO entry layout,
// bit-period and parity calculations.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_e;

  localparam int MaxDataBits = 9;

  typedef struct packed {
    logic                   frame_err;
    logic                   parity_err;
    logic [MaxDataBits-1:0] data;
  } rx_entry_t;

  function automatic int sclk_period(input int clock_freq_hz, input int baud_rate);
    return clock_freq_hz / baud_rate;
  endfunction

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic data_parity(input logic [MaxDataBits-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bundle of the UART receiver: buffered characters with status,
// valid/ready handshake, sticky overrun and fill level.
interface uart_rx_fifo_if #(
  parameter int DataBits  = 8,
  parameter int FifoDepth = 16
);
  logic [DataBits-1:0]        rx_data;
  logic                       rx_parity_err;
  logic                       rx_frame_err;
  logic                       rx_valid;
  logic                       rx_ready;
  logic                       overrun;
  logic                       clr_overrun;
  logic [$clog2(FifoDepth):0] fifo_count;

  modport master (
    output rx_data, rx_parity_err, rx_frame_err, rx_valid, overrun, fifo_count,
    input  rx_ready, clr_overrun
  );

  modport slave (
    input  rx_data, rx_parity_err, rx_frame_err, rx_valid, overrun, fifo_count,
    output rx_ready, clr_overrun
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is still accepted
// when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int Width = 10,
  parameter int Depth = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [Width-1:0]       din,
  input  logic                   pop,
  output logic [Width-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [$clog2(Depth):0] count
);
  localparam int PtrW   = $clog2(Depth);
  localparam int CountW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CountW'(Depth));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign dout     = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format; each character is buffered
// together with its parity and framing status for the core to collect.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int ClockFreqHz = 10000000,
  parameter int BaudRate    = 9600,
  parameter int DataBits    = 8,
  parameter int ParityEn    = 0,
  parameter int ParityOdd   = 0,
  parameter int StopBits    = 1,
  parameter int FifoDepth   = 16
) (
  input logic            clk,
  input logic            rst_n,
  input logic            rx_sig,
  uart_rx_fifo_if.master bus
);
  localparam int SClkPeriod = sclk_period(ClockFreqHz, BaudRate);
  localparam int CntW       = $clog2(SClkPeriod) + 1;
  localparam logic [CntW-1:0] HalfCnt = CntW'(SClkPeriod / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(SClkPeriod - 1);
  localparam logic [3:0] LastData = 4'(DataBits - 1);
  localparam logic [3:0] LastStop = 4'(StopBits - 1);

  if (SClkPeriod < 4) begin : g_bad_period
    $error("uart_rx_fifo: ClockFreqHz/BaudRate must be at least 4");
  end
  if (DataBits < 5 || DataBits > MaxDataBits) begin : g_bad_databits
    $error("uart_rx_fifo: DataBits must lie in 5..9");
  end

  uart_rx_state_e state, next_state;
  logic [1:0]          sync_ff;
  logic                rx_line;
  logic [CntW-1:0]     cnt;
  logic [3:0]          bit_cnt;
  logic [DataBits-1:0] shift;
  logic                parity_err;
  logic                frame_err;
  logic                tick;
  logic                half_tick;
  logic                stop_err;
  logic                last_stop;
  logic                push;
  logic                cnt_clear;
  logic                bit_clear;
  rx_entry_t           push_entry;
  logic                unused_entry_bits;
  logic [DataBits+1:0] fifo_dout;
  logic                fifo_overflow;
  logic                fifo_full;
  logic                fifo_empty;
  logic                overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= 2'b11;
    else        sync_ff <= {sync_ff[0], rx_sig};
  end
  assign rx_line = sync_ff[1];

  assign half_tick = (state == START) && (cnt == HalfCnt);
  assign tick      = (state inside {DATA, PARITY, STOP}) && (cnt == LastCnt);
  assign stop_err  = frame_err | ~rx_line;
  assign last_stop = (state == STOP) && tick && (bit_cnt == LastStop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_line) next_state = START;
      START:   if (half_tick) next_state = rx_line ? IDLE : DATA;
      DATA:    if (tick && bit_cnt == LastData) next_state = (ParityEn != 0) ? PARITY : STOP;
      PARITY:  if (tick) next_state = STOP;
      STOP:    if (last_stop) next_state = stop_err ? BREAK : IDLE;
      BREAK:   if (rx_line) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cnt_clear = (state inside {IDLE, BREAK}) || half_tick || tick;
    bit_clear = (state inside {IDLE, START, PARITY, BREAK}) ||
                ((state == DATA) && tick && (bit_cnt == LastData));
    push      = last_stop;
    push_entry                     = '0;
    push_entry.frame_err           = stop_err;
    push_entry.parity_err          = parity_err;
    push_entry.data[DataBits-1:0]  = shift;
  end

  assign unused_entry_bits = ^push_entry;

  // Timing, shift and error registers; data arrives LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cnt <= cnt_clear ? '0 : cnt + 1'b1;
      if (bit_clear)                                bit_cnt <= '0;
      else if (tick && (state inside {DATA, STOP})) bit_cnt <= bit_cnt + 1'b1;
      if (state == DATA && tick) shift <= {rx_line, shift[DataBits-1:1]};
      if (state == IDLE) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end else begin
        if (state == PARITY && tick)
          parity_err <= data_parity(MaxDataBits'(shift)) ^ rx_line ^ 1'(ParityOdd);
        if (state == STOP && tick && !rx_line)
          frame_err <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .Width (DataBits + 2),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .din      ({push_entry.frame_err, push_entry.parity_err, push_entry.data[DataBits-1:0]}),
    .pop      (bus.rx_ready),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_overflow),
    .count    (bus.fifo_count)
  );

  // A new drop outranks a simultaneous clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               overrun_q <= 1'b0;
    else if (fifo_overflow)   overrun_q <= 1'b1;
    else if (bus.clr_overrun) overrun_q <= 1'b0;
  end

  logic unused_full;
  assign unused_full = fifo_full;

  assign bus.overrun       = overrun_q;
  assign bus.rx_valid      = ~fifo_empty;
  assign bus.rx_frame_err  = fifo_dout[DataBits+1];
  assign bus.rx_parity_err = fifo_dout[DataBits];
  assign bus.rx_data       = fifo_dout[DataBits-1:0];
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 receiver with a 4-deep FIFO and an 8E1
// receiver, both at 10 clocks per bit, checked against a queue model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int P = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line0 = 1'b1;
  logic line1 = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #50 clk = ~clk;

  uart_rx_fifo_if #(.DataBits(8), .FifoDepth(4))  bus0 ();
  uart_rx_fifo_if #(.DataBits(8), .FifoDepth(16)) bus1 ();

  uart_rx_fifo #(
    .ClockFreqHz(10000000), .BaudRate(1000000), .DataBits(8),
    .ParityEn(0), .ParityOdd(0), .StopBits(1), .FifoDepth(4)
  ) dut0 (.clk(clk), .rst_n(rst_n), .rx_sig(line0), .bus(bus0));

  uart_rx_fifo #(
    .ClockFreqHz(10000000), .BaudRate(1000000), .DataBits(8),
    .ParityEn(1), .ParityOdd(0), .StopBits(1), .FifoDepth(16)
  ) dut1 (.clk(clk), .rst_n(rst_n), .rx_sig(line1), .bus(bus1));

  task automatic drive_bit(input int which, input logic b, input int cycles);
    if (which == 0) line0 = b;
    else            line1 = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic use_par,
                            input logic pbit, input logic stop);
    drive_bit(which, 1'b0, P);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], P);
    if (use_par) drive_bit(which, pbit, P);
    drive_bit(which, stop, P);
    drive_bit(which, 1'b1, 2 * P);
  endtask

  // Captures the head entry and pops it with a one-cycle ready pulse.
  task automatic pop_entry(input int which, output logic [9:0] e);
    if (which == 0) begin
      e = {bus0.rx_frame_err, bus0.rx_parity_err, bus0.rx_data};
      bus0.rx_ready = 1'b1;
      @(negedge clk);
      bus0.rx_ready = 1'b0;
    end else begin
      e = {bus1.rx_frame_err, bus1.rx_parity_err, bus1.rx_data};
      bus1.rx_ready = 1'b1;
      @(negedge clk);
      bus1.rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bus0.rx_valid, bus0.fifo_count, bus0.overrun, bus0.rx_data,
         bus0.rx_parity_err, bus0.rx_frame_err} !== 14'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_dut0: got valid=%b cnt=%0d ovr=%b data=%h expected all zero",
               bus0.rx_valid, bus0.fifo_count, bus0.overrun, bus0.rx_data);
    end
    n_checks++;
    if ({bus1.rx_valid, bus1.fifo_count, bus1.overrun} !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_dut1: got valid=%b cnt=%0d ovr=%b expected 0 0 0",
               bus1.rx_valid, bus1.fifo_count, bus1.overrun);
    end
  endtask

  task automatic test_single();
    logic [7:0] d = 8'hA5;
    bus0.rx_ready = 1'b1;
    drive_bit(0, 1'b0, P);
    for (int i = 0; i < 8; i++) drive_bit(0, d[i], P);
    line0 = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (bus0.rx_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_early: rx_valid=%b expected 0 before stop sample", bus0.rx_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({bus0.rx_valid, bus0.rx_frame_err, bus0.rx_parity_err, bus0.rx_data} !== {3'b100, d}) begin
      n_fail++;
      $display("[TB] FAIL single_head: valid=%b fe=%b pe=%b data=%h expected 1 0 0 a5",
               bus0.rx_valid, bus0.rx_frame_err, bus0.rx_parity_err, bus0.rx_data);
    end
    @(negedge clk);
    n_checks++;
    if (bus0.rx_valid !== 1'b0 || bus0.fifo_count !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL single_pop: valid=%b cnt=%0d expected 0 0", bus0.rx_valid, bus0.fifo_count);
    end
    bus0.rx_ready = 1'b0;
    drive_bit(0, 1'b1, 2 * P);
  endtask

  task automatic test_glitch();
    drive_bit(0, 1'b0, 3);
    drive_bit(0, 1'b1, 3 * P);
    n_checks++;
    if (bus0.fifo_count !== 3'd0 || bus0.rx_valid !== 1'b0 || dut0.state !== IDLE) begin
      n_fail++;
      $display("[TB] FAIL glitch: cnt=%0d valid=%b state=%0d expected 0 0 IDLE",
               bus0.fifo_count, bus0.rx_valid, dut0.state);
    end
  endtask

  task automatic test_break();
    logic [9:0] e;
    drive_bit(0, 1'b0, 30 * P);
    n_checks++;
    if (bus0.fifo_count !== 3'd1) begin
      n_fail++;
      $display("[TB] FAIL break_count_low: cnt=%0d expected 1", bus0.fifo_count);
    end
    drive_bit(0, 1'b1, 3 * P);
    n_checks++;
    if (bus0.fifo_count !== 3'd1) begin
      n_fail++;
      $display("[TB] FAIL break_count_high: cnt=%0d expected 1", bus0.fifo_count);
    end
    pop_entry(0, e);
    n_checks++;
    if (e !== 10'h200) begin
      n_fail++;
      $display("[TB] FAIL break_entry: got %h expected 200 (fe=1 data=00)", e);
    end
    send_frame(0, 8'h5C, 1'b0, 1'b0, 1'b1);
    pop_entry(0, e);
    n_checks++;
    if (e !== 10'h05C || bus0.fifo_count !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL break_recover: got %h cnt=%0d expected 05c 0", e, bus0.fifo_count);
    end
  endtask

  task automatic test_overrun();
    logic [9:0] e;
    for (int i = 0; i < 4; i++) send_frame(0, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus0.fifo_count !== 3'd4 || bus0.overrun !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_no_overrun: cnt=%0d ovr=%b expected 4 0", bus0.fifo_count, bus0.overrun);
    end
    send_frame(0, 8'h15, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus0.fifo_count !== 3'd4 || bus0.overrun !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overrun_set: cnt=%0d ovr=%b expected 4 1", bus0.fifo_count, bus0.overrun);
    end
    for (int i = 0; i < 4; i++) begin
      pop_entry(0, e);
      n_checks++;
      if (e !== {2'b00, 8'h11 + 8'(i)}) begin
        n_fail++;
        $display("[TB] FAIL overrun_pop%0d: got %h expected %h", i, e, 8'h11 + 8'(i));
      end
    end
    n_checks++;
    if (bus0.rx_valid !== 1'b0 || bus0.overrun !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overrun_drained: valid=%b ovr=%b expected 0 1", bus0.rx_valid, bus0.overrun);
    end
    bus0.clr_overrun = 1'b1;
    @(negedge clk);
    bus0.clr_overrun = 1'b0;
    n_checks++;
    if (bus0.overrun !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL overrun_clear: ovr=%b expected 0", bus0.overrun);
    end
  endtask

  task automatic test_parity();
    logic [9:0] e;
    logic [9:0] exp_q[$];
    logic [7:0] d;
    logic       pb;
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
    pop_entry(1, e);
    n_checks++;
    if (e !== 10'h103) begin
      n_fail++;
      $display("[TB] FAIL parity_bad: got %h expected 103 (pe=1 data=03)", e);
    end
    pop_entry(1, e);
    n_checks++;
    if (e !== 10'h003) begin
      n_fail++;
      $display("[TB] FAIL parity_good: got %h expected 003", e);
    end
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      exp_q.push_back({1'b0, (($countones(d) + int'(pb)) % 2) == 1, d});
      send_frame(1, d, 1'b1, pb, 1'b1);
    end
    while (exp_q.size() > 0) begin
      pop_entry(1, e);
      n_checks++;
      if (e !== exp_q[0]) begin
        n_fail++;
        $display("[TB] FAIL parity_rand: got %h expected %h", e, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    logic [9:0] exp_q[$];
    logic [7:0] d;
    logic       bad;
    int         n;
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        d   = 8'($urandom);
        bad = ($urandom_range(0, 3) == 0);
        exp_q.push_back({bad, 1'b0, d});
        send_frame(0, d, 1'b0, 1'b0, ~bad);
      end
      n_checks++;
      if (int'(bus0.fifo_count) !== n) begin
        n_fail++;
        $display("[TB] FAIL b2b_count: got %0d expected %0d", bus0.fifo_count, n);
      end
      while (exp_q.size() > 0) begin
        pop_entry(0, e);
        n_checks++;
        if (e !== exp_q[0]) begin
          n_fail++;
          $display("[TB] FAIL b2b_entry: got %h expected %h", e, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] e;
    logic [7:0] d = 8'h5A;
    drive_bit(0, 1'b0, P);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i], P);
    drive_bit(0, d[4], 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_bit(0, 1'b1, 3 * P);
    n_checks++;
    if (bus0.fifo_count !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_empty: cnt=%0d expected 0", bus0.fifo_count);
    end
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus0.fifo_count !== 3'd1) begin
      n_fail++;
      $display("[TB] FAIL midreset_count: cnt=%0d expected 1", bus0.fifo_count);
    end
    pop_entry(0, e);
    n_checks++;
    if (e !== 10'h03C) begin
      n_fail++;
      $display("[TB] FAIL midreset_entry: got %h expected 03c", e);
    end
  endtask

  initial begin
    bus0.rx_ready    = 1'b0;
    bus0.clr_overrun = 1'b0;
    bus1.rx_ready    = 1'b0;
    bus1.clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2 * P) @(negedge clk);
    test_single();
    test_glitch();
    test_break();
    test_overrun();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Synthesisable, parametrised UART receiver. It is the successor to the simulation-only receive monitor.
- Configurable frame format: 5–9 data bits, optional even/odd parity, 1 or 2 stop bits.
- Received characters are buffered in an on-chip FIFO and handed to the core over a valid/ready interface.
- Per-character parity and framing status travel with each character; an overrun flag is sticky.
- Sits between the board RX pin and the core's memory-mapped UART peripheral.

Parameters:
- ClockFreqHz, 10000000, system clock frequency in Hz.
- BaudRate, 9600, line bit rate.
- DataBits, 8, data bits per frame; legal range 5..9.
- ParityEn, 0, 1 = a parity bit follows the data bits.
- ParityOdd, 0, parity sense when ParityEn = 1: 0 = even, 1 = odd.
- StopBits, 1, number of stop bits; 1 or 2.
- FifoDepth, 16, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_sig  input  1  serial line, asynchronous, idle high.
- rx_data  output  DataBits  data at the FIFO head.
- rx_parity_err  output  1  parity error of the head entry.
- rx_frame_err  output  1  framing error of the head entry.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts the head entry.
- overrun  output  1  sticky: a character was dropped because the FIFO was full.
- clr_overrun  input  1  clears overrun.
- fifo_count  output  $clog2(FifoDepth)+1  number of stored entries.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: FSM in IDLE, FIFO empty, rx_valid=0, fifo_count=0, overrun=0, rx_data/rx_parity_err/rx_frame_err=0. Synchronizer flops reset to 1.
- Reset mid-frame: the partial frame is discarded and FIFO contents are lost.
- Input sync: rx_sig passes through 2 flops; all logic uses the synced value.
- Bit timing: localparam SClkPeriod = ClockFreqHz/BaudRate. Elaboration assertion: SClkPeriod >= 4. Bit-time counter width is $clog2(SClkPeriod)+1.
- IDLE: on synced line = 0, clear the counter and go to START.
- START: at count = SClkPeriod/2, sample the line.
  - Sample = 1: glitch; return to IDLE and push nothing.
  - Sample = 0: restart the counter and go to DATA.
- DATA: sample at each count = SClkPeriod-1, i.e. mid-bit. Bits arrive LSB first into a shift register. After DataBits samples, go to PARITY if ParityEn, else to STOP.
- PARITY: sample one bit. parity_err = (XOR of data bits, XOR sampled bit, XOR ParityOdd) != 0. When ParityEn = 0, parity_err is 0.
- STOP: sample StopBits bits; any sample = 0 sets frame_err. On the last stop sample, push {frame_err, parity_err, data}.
  - frame_err = 0: go to IDLE.
  - frame_err = 1: go to BREAK.
- BREAK: wait until the synced line = 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Push latency: the entry is visible at the head (rx_valid=1 if the FIFO was empty) on the cycle after the last stop sample.
- FIFO: show-ahead, so head outputs are valid whenever rx_valid=1. A pop occurs when rx_valid & rx_ready.
- Push with FIFO full and no pop in the same cycle: entry dropped, overrun <= 1, FIFO unchanged.
- Push with FIFO full and pop in the same cycle: push accepted, count unchanged, no overrun.
- Push and pop with FIFO non-full and non-empty: count unchanged.
- rx_ready with FIFO empty: no effect.
- overrun clear: clr_overrun=1 clears overrun. If it coincides with a new overrun event, overrun stays 1 (set wins).
- Wrap: read/write pointers are $clog2(FifoDepth) bits and wrap naturally. fifo_count is separate or derived, range 0..FifoDepth.
- FSM encoding: typedef enum {IDLE, START, DATA, PARITY, STOP, BREAK}. The default branch returns to IDLE, so the FSM has no unreachable lock-up state.

Decomposition:
- Package uart_pkg holds:
  - the uart_rx_state_e typedef;
  - a function computing SClkPeriod from (ClockFreqHz, BaudRate);
  - a parity function;
  - an rx_entry struct packed {frame_err, parity_err, data}.
- Sub-module sync_fifo (Width, Depth) is instantiated with Width = DataBits+2. It provides show-ahead output, full/empty/count, and a full+pop push-allowed rule. It is reused by the future TX block.

Test Plan:
- Format: 8N1, ClockFreqHz=10000000, BaudRate=1000000 (SClkPeriod=10).
- Single character: send 0xA5, rx_ready=1 → one entry, rx_data=0xA5, both error flags 0. rx_valid rises 1 cycle after the stop-bit mid-sample and drops after the pop.
- Parity: ParityEn=1, even parity; send 0x03 with parity bit 1 → rx_data=0x03, rx_parity_err=1. Send 0x03 with parity bit 0 → rx_parity_err=0.
- Framing/break: hold the line low for 30 bit times → exactly one entry with rx_data=0x00 and rx_frame_err=1. No further entries until the line returns high and a new start bit arrives.
- Glitch: a 3-cycle low pulse on an idle line → no entry, FSM back in IDLE, fifo_count=0.
- Overrun: FifoDepth=4, rx_ready=0, send 0x11..0x15 → fifo_count=4, overrun=1. Pops yield 0x11, 0x12, 0x13, 0x14; 0x15 is absent. Pulse clr_overrun → overrun=0.
- Reset mid-frame: assert rst_n low during data bit 4 of 0x5A, release, then send 0x3C → the only entry is 0x3C.
